mem_arbiter: RTL and testbench

- Shares the single memory port between the instruction cache (line-fill reads only) and the write-through data cache (line-fill reads plus posted word writes).
- Absorbs data-cache write-through stores in a small posted-write buffer and drains it when the port is free.
- Arbitrates between the two caches' line fills and enforces read-after-write ordering on buffered lines.
- Sits between both caches and the memory/bus interface.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache fills and a write-through
// dcache, with a posted-write buffer and read-after-write ordering on buffered lines.
module mem_arbiter #(
    parameter int WB_DEPTH   = 4,
    parameter int LINE_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        wb_full,
    output logic        wb_overflow,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int LB = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {ARB_IDLE, ARB_IRD, ARB_DRD, ARB_WR} state_t;

    state_t              r_state, w_next;
    logic [31:0]         r_addr [WB_DEPTH];
    logic [31:0]         r_data [WB_DEPTH];
    logic [3:0]          r_strb [WB_DEPTH];
    logic [WB_DEPTH-1:0] r_vld;
    logic [PW-1:0]       r_head, r_tail;
    logic [PW:0]         r_count;
    logic                r_last_d, r_ovf;
    logic                w_enq, w_deq, w_hit, w_hazard, w_empty, w_upd;

    assign wb_full     = r_count == (PW+1)'(WB_DEPTH);
    assign wb_overflow = r_ovf;
    assign w_empty     = r_count == '0;
    assign w_enq       = d_wr && !wb_full;
    assign w_deq       = r_state == ARB_WR && mem_valid;
    assign w_hazard    = d_rd && w_hit;

    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < WB_DEPTH; k++)
            w_hit = w_hit | (r_vld[k] && r_addr[k][31:LB] == d_addr[31:LB]);
    end

    // Only a contested grant flips the round-robin bit.
    always_comb begin
        w_next = r_state;
        w_upd  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (!w_empty && (wb_full || w_hazard || !(i_rd || d_rd)))
                    w_next = ARB_WR;
                else if (i_rd && d_rd) begin
                    w_next = r_last_d ? ARB_IRD : ARB_DRD;
                    w_upd  = 1'b1;
                end else if (d_rd)
                    w_next = ARB_DRD;
                else if (i_rd)
                    w_next = ARB_IRD;
            end
            ARB_IRD: w_next = i_rd ? ARB_IRD : ARB_IDLE;
            ARB_DRD: w_next = d_rd ? ARB_DRD : ARB_IDLE;
            ARB_WR:  w_next = mem_valid ? ARB_IDLE : ARB_WR;
            default: w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_vld    <= '0;
            r_last_d <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_upd)
                r_last_d <= w_next == ARB_DRD;
            if (w_enq) begin
                r_tail        <= r_tail + 1'b1;
                r_vld[r_tail] <= 1'b1;
            end
            if (w_deq) begin
                r_head        <= r_head + 1'b1;
                r_vld[r_head] <= 1'b0;
            end
            r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_deq);
            if (d_wr && wb_full)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= d_addr;
            r_data[r_tail] <= d_wdata;
            r_strb[r_tail] <= d_wstrb;
        end
    end

    // A granted requester that has dropped rd issues nothing while the grant unwinds.
    assign mem_rd    = (r_state == ARB_IRD && i_rd) || (r_state == ARB_DRD && d_rd);
    assign mem_wr    = r_state == ARB_WR;
    assign mem_addr  = r_state == ARB_WR  ? r_addr[r_head] :
                       r_state == ARB_DRD ? d_addr :
                       r_state == ARB_IRD ? i_addr : '0;
    assign mem_wdata = mem_wr ? r_data[r_head] : '0;
    assign mem_wstrb = mem_wr ? r_strb[r_head] : '0;
    assign i_valid   = r_state == ARB_IRD && i_rd && mem_valid;
    assign d_valid   = r_state == ARB_DRD && d_rd && mem_valid;
    assign i_rdata   = i_valid ? mem_rdata : '0;
    assign d_rdata   = d_valid ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven read arbitration vectors plus hand-written
// write-buffer, ordering, overflow and reset sequences for mem_arbiter.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        i_rd = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_valid, d_valid, wb_full, wb_overflow, mem_rd, mem_wr, mem_valid;
    logic [3:0]  mem_wstrb;
    logic        auto_mem = 1'b0, tv_mv = 1'b0;

    mem_arbiter #(.WB_DEPTH(4), .LINE_BYTES(16)) dut (
        .clk(clk), .rst(rst),
        .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_valid(d_valid), .wb_full(wb_full), .wb_overflow(wb_overflow),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    // Memory model: zero-wait when auto, otherwise driven by the test; data is 0xA0 + word index.
    assign mem_valid = auto_mem ? (mem_rd | mem_wr) : tv_mv;
    assign mem_rdata = 32'hA0 + {30'd0, mem_addr[3:2]};

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ev_t;
    ev_t lg[$];

    always @(posedge clk)
        if (!rst && mem_valid && (mem_rd || mem_wr))
            lg.push_back('{mem_wr, mem_addr, mem_wr ? mem_wdata : mem_rdata, mem_wstrb});

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic        mv;
        logic        emr;
        logic [31:0] ea;
        logic        eiv;
        logic [31:0] eid;
        logic        edv;
        logic [31:0] edd;
    } vec_t;
    vec_t tv[$];

    int errs = 0, checks = 0;

    function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic [31:0] da, input logic mv, input logic emr,
                               input logic [31:0] ea, input logic eiv, input logic [31:0] eid,
                               input logic edv, input logic [31:0] edd);
        return '{ir, ia, dr, da, mv, emr, ea, eiv, eid, edv, edd};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic idle_in();
        i_rd = 1'b0; i_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0; tv_mv = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_in();
        auto_mem = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk1("rst mem_rd", mem_rd, 1'b0);
        chk1("rst mem_wr", mem_wr, 1'b0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk1("rst i_valid", i_valid, 1'b0);
        chk1("rst d_valid", d_valid, 1'b0);
        chk1("rst wb_full", wb_full, 1'b0);
        chk1("rst wb_overflow", wb_overflow, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        lg.delete();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        d_wr = 1'b1; d_addr = a; d_wdata = d; d_wstrb = 4'hF;
        @(negedge clk);
        d_wr = 1'b0; d_wstrb = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        //        ir    ia          dr    da          mv    emr   ea          eiv   eid         edv   edd
        tv.push_back(v(1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h100, 1'b0, 32'h000, 1'b1, 1'b1, 32'h100, 1'b1, 32'hA0, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h104, 1'b0, 32'h000, 1'b0, 1'b1, 32'h104, 1'b0, 32'h00, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h104, 1'b0, 32'h000, 1'b1, 1'b1, 32'h104, 1'b1, 32'hA1, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h108, 1'b0, 32'h000, 1'b1, 1'b1, 32'h108, 1'b1, 32'hA2, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h10C, 1'b0, 32'h000, 1'b1, 1'b1, 32'h10C, 1'b1, 32'hA3, 1'b0, 32'h00));
        tv.push_back(v(1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h100, 1'b1, 32'h400, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h100, 1'b1, 32'h400, 1'b1, 1'b1, 32'h100, 1'b1, 32'hA0, 1'b0, 32'h00));
        tv.push_back(v(1'b0, 32'h000, 1'b1, 32'h400, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 32'h00));
        tv.push_back(v(1'b0, 32'h000, 1'b1, 32'h400, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 32'h00));
        tv.push_back(v(1'b0, 32'h000, 1'b1, 32'h400, 1'b1, 1'b1, 32'h400, 1'b0, 32'h00, 1'b1, 32'hA0));
        tv.push_back(v(1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h100, 1'b1, 32'h404, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h100, 1'b1, 32'h404, 1'b1, 1'b1, 32'h404, 1'b0, 32'h00, 1'b1, 32'hA1));
        tv.push_back(v(1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 32'h00));
        tv.push_back(v(1'b1, 32'h100, 1'b0, 32'h000, 1'b1, 1'b1, 32'h100, 1'b1, 32'hA0, 1'b0, 32'h00));
        tv.push_back(v(1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00, 1'b0, 32'h00));

        // Icache line fill, then two contested grants alternating I then D.
        do_reset();
        for (int k = 0; k < tv.size(); k++) begin
            i_rd = tv[k].ir; i_addr = tv[k].ia; d_rd = tv[k].dr; d_addr = tv[k].da; tv_mv = tv[k].mv;
            #1;
            chk1($sformatf("v%0d mem_rd", k), mem_rd, tv[k].emr);
            chk1($sformatf("v%0d mem_wr", k), mem_wr, 1'b0);
            chk1($sformatf("v%0d i_valid", k), i_valid, tv[k].eiv);
            chk($sformatf("v%0d i_rdata", k), i_rdata, tv[k].eid);
            chk1($sformatf("v%0d d_valid", k), d_valid, tv[k].edv);
            chk($sformatf("v%0d d_rdata", k), d_rdata, tv[k].edd);
            if (tv[k].emr)
                chk($sformatf("v%0d mem_addr", k), mem_addr, tv[k].ea);
            @(negedge clk);
        end
        idle_in();

        // Dcache fill waits for buffered writes to its line.
        do_reset();
        auto_mem = 1'b1;
        wr(32'h200, 32'h11);
        wr(32'h204, 32'h22);
        wr(32'h300, 32'h33);
        d_rd = 1'b1; d_addr = 32'h208;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            #1;
            if (d_valid) begin
                got = 1'b1;
                chk("s3 d_rdata", d_rdata, 32'hA2);
            end
            @(negedge clk);
        end
        chk1("s3 d_valid seen", got, 1'b1);
        d_rd = 1'b0;
        repeat (10) @(negedge clk);
        chk("s3 log size", 32'(lg.size()), 32'd4);
        if (lg.size() == 4) begin
            chk("s3 ev0 addr", lg[0].a, 32'h200);
            chk("s3 ev0 data", lg[0].d, 32'h11);
            chk("s3 ev0 strb", {28'd0, lg[0].s}, 32'hF);
            chk("s3 ev1 addr", lg[1].a, 32'h204);
            chk("s3 ev1 data", lg[1].d, 32'h22);
            chk1("s3 ev2 is read", lg[2].wr, 1'b0);
            chk("s3 ev2 addr", lg[2].a, 32'h208);
            chk1("s3 ev3 is write", lg[3].wr, 1'b1);
            chk("s3 ev3 addr", lg[3].a, 32'h300);
        end

        // Fill the buffer under a locked icache fill, overflow, then in-order drain.
        do_reset();
        i_rd = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            wr(32'h500 + 32'(4 * k), 32'h51 + 32'(k));
            #1;
            chk1($sformatf("s4 wb_full after %0d", k + 1), wb_full, k == 3);
        end
        chk1("s4 no overflow yet", wb_overflow, 1'b0);
        wr(32'h510, 32'h55);
        #1;
        chk1("s4 overflow", wb_overflow, 1'b1);
        chk1("s4 still full", wb_full, 1'b1);
        chk1("s4 fill locked", mem_rd, 1'b1);
        chk1("s4 no write during fill", mem_wr, 1'b0);
        tv_mv = 1'b1;
        #1;
        chk1("s4 i_valid", i_valid, 1'b1);
        @(negedge clk);
        i_rd = 1'b0; tv_mv = 1'b0; auto_mem = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            #1;
            if (mem_wr) got = 1'b1;
            else @(negedge clk);
        end
        chk1("s4 write started", got, 1'b1);
        chk1("s4 full before dequeue", wb_full, 1'b1);
        chk("s4 first write addr", mem_addr, 32'h500);
        @(negedge clk);
        #1;
        chk1("s4 full drops", wb_full, 1'b0);
        repeat (20) @(negedge clk);
        chk("s4 log size", 32'(lg.size()), 32'd5);
        if (lg.size() == 5)
            for (int k = 1; k < 5; k++) begin
                chk($sformatf("s4 w%0d addr", k), lg[k].a, 32'h500 + 32'(4 * (k - 1)));
                chk($sformatf("s4 w%0d data", k), lg[k].d, 32'h51 + 32'(k - 1));
            end
        chk1("s4 overflow sticky", wb_overflow, 1'b1);

        // Enqueue and dequeue in the same cycle at count 3.
        do_reset();
        wr(32'h600, 32'h61);
        wr(32'h604, 32'h62);
        wr(32'h608, 32'h63);
        d_wr = 1'b1; d_addr = 32'h60C; d_wdata = 32'h64; d_wstrb = 4'hF; tv_mv = 1'b1;
        #1;
        chk1("s5 draining", mem_wr, 1'b1);
        chk("s5 head addr", mem_addr, 32'h600);
        @(negedge clk);
        d_wr = 1'b0; tv_mv = 1'b0;
        #1;
        chk1("s5 count stays 3", wb_full, 1'b0);
        wr(32'h610, 32'h65);
        #1;
        chk1("s5 full at 4", wb_full, 1'b1);
        auto_mem = 1'b1;
        repeat (20) @(negedge clk);
        chk("s5 log size", 32'(lg.size()), 32'd5);
        if (lg.size() == 5)
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("s5 w%0d addr", k), lg[k].a, 32'h600 + 32'(4 * k));
                chk($sformatf("s5 w%0d data", k), lg[k].d, 32'h61 + 32'(k));
            end

        // Asynchronous reset in the middle of a dcache burst.
        do_reset();
        d_rd = 1'b1; d_addr = 32'h700;
        @(negedge clk);
        tv_mv = 1'b1;
        d_wr = 1'b1; d_wdata = 32'h77; d_wstrb = 4'hF;
        #1;
        chk1("s6 beat1 d_valid", d_valid, 1'b1);
        chk("s6 beat1 d_rdata", d_rdata, 32'hA0);
        @(negedge clk);
        d_wr = 1'b0; d_wstrb = 4'h0; d_addr = 32'h704; tv_mv = 1'b0;
        @(negedge clk);
        tv_mv = 1'b1;
        rst = 1'b1;
        #1;
        chk1("s6 mem_rd", mem_rd, 1'b0);
        chk1("s6 mem_wr", mem_wr, 1'b0);
        chk("s6 mem_addr", mem_addr, 32'h0);
        chk("s6 mem_wdata", mem_wdata, 32'h0);
        chk1("s6 d_valid", d_valid, 1'b0);
        chk("s6 d_rdata", d_rdata, 32'h0);
        chk1("s6 i_valid", i_valid, 1'b0);
        chk("s6 i_rdata", i_rdata, 32'h0);
        chk1("s6 wb_full", wb_full, 1'b0);
        chk1("s6 wb_overflow", wb_overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0; d_rd = 1'b0; tv_mv = 1'b0;
        lg.delete();
        auto_mem = 1'b1;
        i_rd = 1'b1; i_addr = 32'h100;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (i_valid) begin
                got = 1'b1;
                chk("s6 i_rdata", i_rdata, 32'hA0);
            end
            @(negedge clk);
        end
        chk1("s6 i_valid seen", got, 1'b1);
        i_rd = 1'b0;
        repeat (10) @(negedge clk);
        chk("s6 buffer emptied", 32'(lg.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
